lsl_seq: RTL and testbench
==========================

Name: lsl_seq

Overview:
- Multi-cycle logical-shift-left unit for the ARM datapath; the left-shifting counterpart of the single-cycle arithmetic right shifter.
- Implements LSL-by-register semantics (8-bit shift amount, carry-out) iteratively, STEP bit positions per cycle, to save area.
- Sits between operand fetch and the ALU behind a valid/ready handshake on both sides.
- Works on a 33-bit internal value {carry, data}, so saturating amounts fall out naturally.

Parameters:
- STEP, 4, bit positions shifted per SHIFT cycle; power of two, 1..32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort: drop any in-flight operation and return to IDLE.
- in_valid  input  1  operand request valid.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- in_data  input  32  value to shift.
- in_sh  input  8  shift amount, unsigned 0..255.
- in_carry  input  1  current C flag; used as carry-out when in_sh==0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  32  shifted result.
- out_carry  output  1  shifter carry-out.

Behaviour:
- States: IDLE, SHIFT, DONE. Reset (or flush) -> IDLE, acc=0, cnt=0. out_valid=0, out_data=0, out_carry=0; in_ready=1 once in IDLE.
- Accept: in_valid && in_ready at an edge.
  - acc <= {in_carry, in_data}.
  - cnt <= min(in_sh, 33) (6-bit).
  - Next state SHIFT if cnt!=0, else DONE.
- SHIFT: each cycle k = min(cnt, STEP); acc <= acc << k (33-bit, zero fill; bit 32 takes data[32-k]); cnt <= cnt - k. When the new cnt==0, go to DONE.
- DONE: out_valid=1, out_data=acc[31:0], out_carry=acc[32], held stable while out_ready=0. On out_ready, go to IDLE; in_ready=1 the next cycle. No same-cycle reaccept.
- Resulting semantics:
  - sh=0: data unchanged, carry=in_carry.
  - 1..31: data<<sh, carry=in_data[32-sh].
  - sh=32: data 0, carry=in_data[0].
  - sh>=33: data 0, carry 0.
- Latency, accept edge to out_valid high: 1 + ceil(min(sh,33)/STEP) cycles (sh=0 -> 1 cycle).
- in_valid while busy: ignored; in_ready=0, so the request is not consumed.
- flush has priority over all handshakes: an accept in the same cycle as flush is discarded; out_valid falls the next cycle.
- rst has priority over flush; reset mid-operation behaves as a flush.
- out_data/out_carry are registered. Value outside DONE: last acc, not guaranteed; consumers qualify with out_valid.

Optional Feature:
- Macro LSL_SEQ_SAT_BYPASS_EN.
- Defined: on accept with in_sh>=32, the result is computed directly: acc <= {(in_sh==32) ? in_data[0] : 0, 32'h0}, cnt <= 0, next state DONE. Latency is 1 cycle for all in_sh>=32.
- Undefined: these amounts iterate through SHIFT like any other (e.g. 9 cycles for sh=32 at STEP=4).
- Results are bit-identical either way.

Test Plan:
- STEP=4, in_data=0x80000001, in_sh=1, in_carry=0 -> out_data=0x00000002, out_carry=1, out_valid 2 cycles after accept.
- in_data=0x12345678, in_sh=0, in_carry=1 -> out_data=0x12345678, out_carry=1, latency 1.
- in_data=0x00000001, in_sh=32 -> out_data=0, out_carry=1; latency 9 without macro, 1 with macro.
- in_data=0xFFFFFFFF, in_sh=200 -> out_data=0, out_carry=0. in_sh=31 on 0x00000003 -> out_data=0x80000000, out_carry=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_data, out_carry stable, in_ready=0. Then out_ready=1 -> IDLE and in_ready=1 next cycle.
- Assert flush 2 cycles into an sh=20 operation (and separately rst) -> IDLE next cycle, no out_valid pulse. A following request sh=4 on 0x0000000F -> out_data=0x000000F0, out_carry=0.

Source files
------------

// File: rtl/lsl_seq.sv
// Iterative 33-bit logical-shift-left ({carry, data}), STEP positions per cycle.
// Optional LSL_SEQ_SAT_BYPASS_EN resolves in_sh>=32 directly on accept.
module lsl_seq #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [7:0]  in_sh,
  input  logic        in_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_carry
);
  localparam logic [5:0] STEP6 = 6'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [32:0] acc;
  logic [5:0]  cnt;
  logic [5:0]  k;
  logic [5:0]  sh_sat;
  logic [5:0]  cnt_nxt;

  assign k       = (cnt > STEP6) ? STEP6 : cnt;
  assign cnt_nxt = cnt - k;
  // Amounts past 33 all clear the 33-bit value, so 33 stands in for them.
  assign sh_sat  = (in_sh > 8'd33) ? 6'd33 : in_sh[5:0];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
`ifdef LSL_SEQ_SAT_BYPASS_EN
            if (in_sh >= 8'd32) begin
              acc   <= {(in_sh == 8'd32) ? in_data[0] : 1'b0, 32'h0};
              cnt   <= '0;
              state <= DONE;
            end else begin
              acc   <= {in_carry, in_data};
              cnt   <= sh_sat;
              state <= (sh_sat != 6'd0) ? SHIFT : DONE;
            end
`else
            acc   <= {in_carry, in_data};
            cnt   <= sh_sat;
            state <= (sh_sat != 6'd0) ? SHIFT : DONE;
`endif
          end
        end
        SHIFT: begin
          acc <= acc << k;
          cnt <= cnt_nxt;
          if (cnt_nxt == 6'd0) state <= DONE;
        end
        DONE: begin
          // Result is published one cycle after entering DONE, then held.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc[31:0];
            out_carry <= acc[32];
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsl_seq.sv
// Table-driven bench for lsl_seq with a result scoreboard and flush/reset sequences.
module tb_lsl_seq;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_carry;
  logic        out_valid, out_ready, out_carry;
  logic [31:0] in_data, out_data;
  logic [7:0]  in_sh;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  sh;
    logic        carry;
    logic [31:0] exp_data;
    logic        exp_carry;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        c;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  lsl_seq #(.STEP(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sh(in_sh), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] sh);
    int m;
    m = (sh > 8'd33) ? 33 : int'(sh);
`ifdef LSL_SEQ_SAT_BYPASS_EN
    if (sh >= 8'd32) return 1;
`endif
    return 1 + (m + 3) / 4;
  endfunction

  // Drive one request, measure latency, check the popped expectation.
  task automatic run_op(input vec_t v, input string tag);
    int   lat;
    exp_t e;
    logic [31:0] hd;
    logic        hc;
    chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    in_data = v.data; in_sh = v.sh; in_carry = v.carry; in_valid = 1'b1;
    sb.push_back('{d: v.exp_data, c: v.exp_carry});
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat(v.sh)));
    if (out_valid) begin
      e = sb.pop_front();
      chk({tag, " data"}, out_data, e.d);
      chk({tag, " carry"}, 32'(out_carry), 32'(e.c));
      hd = out_data; hc = out_carry;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
        chk({tag, " hold data"}, out_data, hd);
        chk({tag, " hold carry"}, 32'(out_carry), 32'(hc));
        chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready after"}, 32'(in_ready), 32'd1);
    end else begin
      void'(sb.pop_front());
      checks++; errors++;
      $display("FAIL %s timeout: out_valid never rose within 100 cycles", tag);
    end
  endtask

  // Abort an sh=20 operation two cycles in using flush or rst.
  task automatic abort_op(input bit use_rst, input string tag);
    int seen;
    in_data = 32'hCAFEBABE; in_sh = 8'd20; in_carry = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk({tag, " no out_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h80000001, 8'd1,   1'b0, 32'h00000002, 1'b1, 5};
    vecs[1] = '{32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1, 0};
    vecs[2] = '{32'h00000001, 8'd32,  1'b0, 32'h00000000, 1'b1, 0};
    vecs[3] = '{32'hFFFFFFFF, 8'd200, 1'b1, 32'h00000000, 1'b0, 0};
    vecs[4] = '{32'h00000003, 8'd31,  1'b0, 32'h80000000, 1'b1, 0};
    vecs[5] = '{32'h0000000F, 8'd4,   1'b1, 32'h000000F0, 1'b0, 0};
    vecs[6] = '{32'hA5A5A5A5, 8'd33,  1'b1, 32'h00000000, 1'b0, 1};
    vecs[7] = '{32'h12345678, 8'd7,   1'b0, 32'h1A2B3C00, 1'b1, 0};
    vecs[8] = '{32'hDEADBEEF, 8'd16,  1'b0, 32'hBEEF0000, 1'b1, 0};
    vecs[9] = '{32'h40000000, 8'd2,   1'b1, 32'h00000000, 1'b1, 0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_sh = '0; in_carry = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_carry", 32'(out_carry), 32'd0);

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    abort_op(1'b0, "flush");
    run_op('{32'h0000000F, 8'd4, 1'b0, 32'h000000F0, 1'b0, 0}, "post_flush");
    abort_op(1'b1, "rst");
    run_op('{32'h0000000F, 8'd4, 1'b0, 32'h000000F0, 1'b0, 0}, "post_rst");

    // An accept coinciding with flush must be dropped.
    in_data = 32'h1; in_sh = 8'd0; in_carry = 1'b1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("flush_accept out_valid", 32'(out_valid), 32'd0);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
